// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline constants, FSM states and forwarding select codes
package pipe_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_INIT = 2'b00,
    ST_RUN  = 2'b01,
    ST_WAIT = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_e;

endpackage

// File: rtl/pipe_ctrl_fwd_unit.sv
// rtl/pipe_ctrl_fwd_unit.sv - operand forwarding select for one EX source register
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_reg_write,
  output logic [1:0]       fwd
);

  // MEM holds the younger result, so it is checked first
  always_comb begin
    fwd = FWD_RF;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs)) begin
      fwd = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs)) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard controller: init flush, freeze, redirect, load-use, forwarding
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             mem_reg_write,
  input  logic             wb_reg_write,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_we,
  output logic             id_ex_flush,
  output logic             ex_mem_we,
  output logic             ex_mem_flush,
  output logic             mem_wb_we,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   init_cnt_q, init_cnt_d;
  logic            load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

  assign state = state_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= IW'(INIT_CYCLES);
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_we     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_we    = 1'b1;
    ex_mem_flush = 1'b0;
    mem_wb_we    = 1'b1;
    mem_wb_flush = 1'b0;
    case (state_q)
      ST_INIT: begin
        pc_we        = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        if (init_cnt_q <= IW'(1)) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q - IW'(1);
        end
      end
      default: begin
        // Freezing holds EX/ID, so a pending redirect or load-use is re-seen on release
        if (mem_busy) begin
          pc_we     = 1'b0;
          if_id_we  = 1'b0;
          id_ex_we  = 1'b0;
          ex_mem_we = 1'b0;
          mem_wb_we = 1'b0;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_RUN;
          if (ex_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if ((state_q != ST_INIT) && !pc_we && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  fwd_unit u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_a)
  );

  fwd_unit u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd           (fwd_b)
  );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: INIT_CYCLES, default 2, number of post-reset cycles spent flushing all pipeline registers.
REQ-002 Parameter: CNT_W, default 16, width of the stall-cycle counter.
REQ-003 Clk  in  1  single clock; all state updates on posedge Clk.
REQ-004 Rst_n  in  1  asynchronous, active-low reset.
REQ-005 id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
REQ-006 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 or rs2.
REQ-007 ex_rs1, ex_rs2, ex_rd  in  5 each  EX-stage register fields.
REQ-008 ex_mem_read  in  1  EX instruction is a load.
REQ-009 mem_rd, wb_rd  in  5 each; mem_reg_write, wb_reg_write  in  1 each  MEM and WB destination fields and write flags.
REQ-010 ex_redirect  in  1  branch taken or jump resolved in EX.
REQ-011 mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-012 pc_we  out  1  PC write enable.
REQ-013 if_id_we/flush, id_ex_we/flush, ex_mem_we/flush, mem_wb_we/flush  out  1 each  controls for the four pipeline registers; a flush takes effect only with we=1.
REQ-014 fwd_a, fwd_b  out  2 each  EX operand select: 00 register file, 01 MEM result, 10 WB result.
REQ-015 state  out  2  FSM state: 00 INIT, 01 RUN, 10 WAIT.
REQ-016 stall_cnt  out  CNT_W  saturating count of frozen or stalled cycles.

Function
REQ-017 Control outputs SHALL be combinational (Mealy) functions of the current state and inputs; state and stall_cnt are registered.
REQ-018 In INIT, the block SHALL drive pc_we=0 and every *_we=1 and *_flush=1; it SHALL move to RUN after INIT_CYCLES cycles, using an internal down-counter.
REQ-019 In RUN or WAIT, priority SHALL be: mem_busy > ex_redirect > load-use > normal.
REQ-020 mem_busy=1: all *_we=0, pc_we=0, all flush=0; next state WAIT; a coincident redirect or load-use SHALL be deferred, not lost, because EX/ID hold.
REQ-021 In WAIT with mem_busy=0, the block SHALL apply RUN rules in that same cycle (zero-cycle release) and go to RUN.
REQ-022 ex_redirect=1 (no mem_busy): pc_we=1, if_id_flush=1, id_ex_flush=1, all we=1; ex_mem and mem_wb pass normally; load-use is ignored.
REQ-023 Load-use is ex_mem_read && ex_rd!=0 && ((id_use_rs1 && ex_rd==id_rs1) || (id_use_rs2 && ex_rd==id_rs2)); it SHALL drive pc_we=0, if_id_we=0, id_ex_we=1, id_ex_flush=1 (bubble), with the rest passing; the stall lasts exactly one cycle.
REQ-024 Normal operation: every we=1 and every flush=0.
REQ-025 fwd_a SHALL be 01 if mem_reg_write && mem_rd!=0 && mem_rd==ex_rs1, else 10 if wb_reg_write && wb_rd!=0 && wb_rd==ex_rs1, else 00; fwd_b is the same using ex_rs2; MEM wins ties; forwarding is active in all states.
REQ-026 stall_cnt SHALL increment when pc_we=0 in RUN or WAIT and saturate at all-ones; it is never incremented in INIT and is never wrapped.

Reset
REQ-027 Rst_n=0 SHALL immediately set state=INIT, init counter=INIT_CYCLES, and stall_cnt=0; outputs then follow INIT rules.
REQ-028 Reset asserted mid-stall or mid-WAIT SHALL abandon the pending operation; no state survives.

Structure
REQ-029 The state encodings and the fwd select codes SHALL live in the shared pipeline package, and the 5-bit register-index width SHALL be a package constant.
REQ-030 Forwarding SHALL be one sub-module, fwd_unit, instantiated twice (operand A and operand B); the FSM, stall logic and counter stay in pipe_ctrl.

Verification
REQ-031 Reset release with INIT_CYCLES=2 -> two cycles of pc_we=0 with all flush=1, then state=01 and normal enables.
REQ-032 ex_mem_read=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle of pc_we=0, if_id_we=0, id_ex_flush=1; stall_cnt +1.
REQ-033 mem_busy high 3 cycles with ex_redirect=1 throughout -> 3 frozen cycles (state=10, stall_cnt +3), then a redirect flush in the release cycle.
REQ-034 mem_rd=wb_rd=7, both write flags set, ex_rs1=7, ex_rs2=0 -> fwd_a=01, fwd_b=00; with mem_reg_write=0 -> fwd_a=10.
REQ-035 ex_redirect and load-use in the same cycle -> flush applied, pc_we=1, no stall, stall_cnt unchanged.
REQ-036 Force stall_cnt to saturate (CNT_W=4, 20 busy cycles) -> it holds at 15; an Rst_n pulse mid-WAIT -> state=00, stall_cnt=0.
